// File: rtl/uart8_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart8_receiver
// Brief    : 8N1 UART receiver, oversampled by an external en tick strobe.
// Revision : 1.0 - initial release
// ============================================================================
module uart8_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in,
    output logic [7:0] out,
    output logic       done,
    output logic       busy,
    output logic       err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START_BIT = 3'd1;
    localparam logic [2:0] DATA_BITS = 3'd2;
    localparam logic [2:0] STOP_BIT  = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic          sync1_q, sync2_q;
    logic          rx_s;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    out_q, out_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    assign rx_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START_BIT;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                START_BIT: begin
                    // Mid-bit recheck rejects short glitches on the line.
                    if (cnt_q == HALF_M1) begin
                        cnt_d = '0;
                        if (!rx_s) begin
                            state_d = DATA_BITS;
                            bit_d   = 3'd0;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DATA_BITS: begin
                    if (cnt_q == FULL_M1) begin
                        shift_d = {rx_s, shift_q[7:1]};
                        cnt_d   = '0;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = STOP_BIT;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STOP_BIT: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                        if (rx_s) begin
                            out_d   = shift_q;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not look like a new start bit.
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            out_q   <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart8_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart8_receiver
// Brief    : Directed self-checking bench for uart8_receiver (OVERSAMPLE=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart8_receiver;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rx;
    logic [7:0] out;
    logic       done;
    logic       busy;
    logic       err;

    int checks   = 0;
    int failures = 0;

    logic       en_run;
    int         ediv;
    int         tick_no;
    int         done_cnt  = 0;
    int         done_tick = 0;
    int         fall_tick = 0;
    int         wide_cnt  = 0;
    logic       prev_done = 1'b0;
    logic [7:0] done_out [0:15];
    logic       done_err [0:15];

    uart8_receiver #(.OVERSAMPLE(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .in   (rx),
        .out  (out),
        .done (done),
        .busy (busy),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // en is high every 4th clk; tick_no labels the posedge the tick lands on.
    initial begin
        en      = 1'b0;
        ediv    = 0;
        tick_no = 0;
        forever begin
            @(negedge clk);
            ediv = (ediv + 1) % 4;
            if (en_run && ediv == 0) begin
                en = 1'b1;
                tick_no++;
            end else begin
                en = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_out[done_cnt % 16] = out;
            done_err[done_cnt % 16] = err;
            done_tick = tick_no;
            done_cnt++;
        end
        if (done && prev_done) wide_cnt++;
        if (err && !done) wide_cnt++;
        prev_done = done;
    end

    initial begin
        #600000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!en) @(posedge clk);
        end
    endtask

    task automatic drive(input logic v);
        @(negedge clk);
        rx = v;
    endtask

    // Sends start + 8 data bits + stop; optionally stalls en mid data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int stall_bit);
        int n0;
        drive(1'b0);
        fall_tick = tick_no;
        wait_ticks(16);
        check("busy_mid", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            drive(d[i]);
            if (i == stall_bit) begin
                wait_ticks(8);
                n0     = done_cnt;
                en_run = 1'b0;
                repeat (100) @(posedge clk);
                check("stall_busy", {31'd0, busy}, 32'd1);
                check("stall_nodone", done_cnt, n0);
                en_run = 1'b1;
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
        end
        drive(stop);
        wait_ticks(16);
    endtask

    function automatic logic lat_ok(input int d);
        return (d >= 152 && d <= 154);
    endfunction

    initial begin
        int n0;
        rst    = 1'b1;
        rx     = 1'b1;
        en_run = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_out",  {24'd0, out}, 32'h00);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err",  {31'd0, err}, 32'd0);
        rst = 1'b0;
        wait_ticks(4);

        // Good frame 0xA5
        send_frame(8'hA5, 1'b1, -1);
        check("a5_cnt",  done_cnt, 1);
        check("a5_out",  {24'd0, done_out[0]}, 32'hA5);
        check("a5_err",  {31'd0, done_err[0]}, 32'd0);
        check("a5_lat",  {31'd0, lat_ok(done_tick - fall_tick)}, 32'd1);
        check("a5_idle", {31'd0, busy}, 32'd0);
        wait_ticks(8);

        // Short low glitch is rejected
        drive(1'b0);
        wait_ticks(4);
        drive(1'b1);
        wait_ticks(20);
        check("gl_cnt",  done_cnt, 1);
        check("gl_busy", {31'd0, busy}, 32'd0);
        check("gl_out",  {24'd0, out}, 32'hA5);

        // Framing error followed by a break of 40 ticks low
        send_frame(8'h3C, 1'b0, -1);
        wait_ticks(24);
        check("brk_cnt",  done_cnt, 2);
        check("brk_err",  {31'd0, done_err[1]}, 32'd1);
        check("brk_out",  {24'd0, done_out[1]}, 32'hA5);
        check("brk_hold", {24'd0, out}, 32'hA5);
        check("brk_busy", {31'd0, busy}, 32'd0);
        drive(1'b1);
        wait_ticks(16);
        send_frame(8'h5A, 1'b1, -1);
        check("5a_cnt", done_cnt, 3);
        check("5a_out", {24'd0, done_out[2]}, 32'h5A);
        check("5a_err", {31'd0, done_err[2]}, 32'd0);
        wait_ticks(8);

        // Back-to-back 0x00 then 0xFF with no idle gap
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        check("b2b_cnt",  done_cnt, 5);
        check("b2b_out0", {24'd0, done_out[3]}, 32'h00);
        check("b2b_err0", {31'd0, done_err[3]}, 32'd0);
        check("b2b_out1", {24'd0, done_out[4]}, 32'hFF);
        check("b2b_err1", {31'd0, done_err[4]}, 32'd0);
        wait_ticks(8);

        // en stalled for 100 clks inside data bit 3
        send_frame(8'h96, 1'b1, 3);
        check("stl_cnt", done_cnt, 6);
        check("stl_out", {24'd0, done_out[5]}, 32'h96);
        check("stl_lat", {31'd0, lat_ok(done_tick - fall_tick)}, 32'd1);
        wait_ticks(8);

        // Reset during data bit 4 of 0x81
        n0 = done_cnt;
        drive(1'b0);
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            drive(i == 0);
            wait_ticks(16);
        end
        drive(1'b0);
        wait_ticks(8);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_out",  {24'd0, out}, 32'h00);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_err",  {31'd0, err}, 32'd0);
        rst = 1'b0;
        wait_ticks(200);
        check("mrst_nodone", done_cnt, n0);
        check("mrst_idle",   {31'd0, busy}, 32'd0);
        send_frame(8'h42, 1'b1, -1);
        check("42_cnt", done_cnt, n0 + 1);
        check("42_out", {24'd0, out}, 32'h42);

        check("pulse_width", wide_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart8_receiver.md
UART8_RECEIVER -- requirements
Module: uart8_receiver

Interface
REQ-001 Parameter OVERSAMPLE, default 16, is the number of en ticks per bit period; legal values are even, 4..64.
REQ-002 Port: clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: en  input  1  oversample tick strobe at OVERSAMPLE x baud; the block SHALL advance only when en=1.
REQ-005 Port: in  input  1  asynchronous serial rx line; idle high; LSB first; 8N1 framing.
REQ-006 Port: out  output  8  last correctly framed byte received.
REQ-007 Port: done  output  1  one-clk pulse marking the end of a frame, whether good or errored.
REQ-008 Port: busy  output  1  high while a frame is being received.
REQ-009 Port: err  output  1  framing-error flag; valid only in the cycle done=1.

Function
REQ-010 in SHALL pass through a 2-FF synchronizer (both FFs reset to 1); all decisions SHALL use the synchronized value rx_s.
REQ-011 The FSM SHALL have exactly these states: IDLE, START_BIT, DATA_BITS, STOP_BIT, WAIT_HIGH.
REQ-012 In cycles with en=0, the state, tick counter, bit index and shift register SHALL hold; done and err SHALL still deassert after their pulse.
REQ-013 IDLE: on en=1 with rx_s=0 -> go to START_BIT, tick counter = 0, busy <= 1.
REQ-014 START_BIT: the tick counter SHALL increment per en tick; at the en tick with counter == OVERSAMPLE/2-1, sample rx_s (mid-bit).
- Sample = 0 -> go to DATA_BITS, counter = 0, bit index = 0.
- Sample = 1 -> glitch: go to IDLE, busy <= 0, no done.
REQ-015 DATA_BITS: at each en tick with counter == OVERSAMPLE-1, shift rx_s into the shift register MSB side (LSB-first frame), reset the counter, and increment the bit index.
- After the 8th sample, go to STOP_BIT with counter = 0.
REQ-016 STOP_BIT: at the en tick with counter == OVERSAMPLE-1, sample rx_s.
- Sample = 1 -> out <= shift register, err <= 0, done <= 1, busy <= 0, go to IDLE.
- Sample = 0 -> out unchanged, err <= 1, done <= 1, busy <= 0, go to WAIT_HIGH.
REQ-017 WAIT_HIGH: go to IDLE only on an en tick with rx_s=1; this prevents a break condition from being taken as a new start.
REQ-018 done and err SHALL be high for exactly one clk and SHALL return to 0 in the following clk.
REQ-019 out SHALL hold its value between good frames and SHALL never expose partial shift data.
REQ-020 From the falling edge on in to done, the latency SHALL be 2 synchronizer clks + detect tick + (OVERSAMPLE/2 + 9*OVERSAMPLE) en ticks + 1 clk, with +/-1 en tick of detection jitter.
REQ-021 If in falls during the same en tick that returns the FSM to IDLE, that fall SHALL be detected on the next en tick (back-to-back frames with no idle gap are supported).
REQ-022 Counter widths SHALL be ceil(log2(OVERSAMPLE)) bits for the tick counter and 3 bits for the bit index; no wrap-around SHALL be possible within legal parameters.

Reset
REQ-023 While rst=1 at a clk edge: state = IDLE, out = 8'h00, done = 0, busy = 0, err = 0, counters = 0, shift register = 0, synchronizer FFs = 1.
REQ-024 rst asserted mid-frame SHALL abort the frame with no done pulse; after rst deasserts, the block SHALL wait in IDLE for a new falling edge.

Verification
REQ-025 OVERSAMPLE=16, en every 4th clk, frame 0xA5 with stop=1 -> out=8'hA5, one done pulse, err=0, busy high from start detection until done.
REQ-026 in low for 4 en ticks, then high -> no done, busy returns to 0, out unchanged.
REQ-027 Frame 0x3C with stop bit = 0, in held low for 40 ticks -> done=1 and err=1 for one clk, out keeps its previous value, no new frame until in goes high, then frame 0x5A is received correctly.
REQ-028 Back-to-back frames 0x00 then 0xFF with no idle gap -> two done pulses, out=8'h00 then 8'hFF, err=0 both times.
REQ-029 rst pulsed at data bit 4 of 0x81 -> no done, outputs at reset values, next frame 0x42 -> out=8'h42.
REQ-030 en held low for 100 clks mid-frame, then resumed -> frame completes with the correct byte; no counter advanced during the stall.
